sequence_capture_controller: RTL and testbench

- Schedules the key-sequence detector on the TVP5147M1 decoder path.
- Holds the detector in reset except on one designated line per field.
- On that line, captures the 32-bit word the detector reports and debounces it across fields.
- Publishes a confirmed descrambler key with valid/update flags, and drops the key after a run of fields with no capture.

---
 rtl/sequence_capture_controller.sv | 192 +++++++++++++++++++
 tb/tb_sequence_capture_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_capture_controller.sv
// Key-sequence capture scheduler: gates the detector to one line per field, debounces
// captured words and publishes the descrambler key. Optional counters: SEQ_CAPTURE_STATS_EN.
module sequence_capture_controller #(
    parameter int unsigned KEY_LINE       = 22,
    parameter int unsigned CONFIRM_COUNT  = 2,
    parameter int unsigned TIMEOUT_FIELDS = 8,
    parameter int unsigned LINE_BITS      = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        hsync,
    input  logic        active_video,
    input  logic        det_ready,
    input  logic [31:0] det_sequence,
    output logic        det_reset_n,
    output logic [31:0] key,
    output logic        key_valid,
    output logic        key_update,
    output logic        capture_miss
`ifdef SEQ_CAPTURE_STATS_EN
    ,
    output logic [15:0] miss_total,
    output logic [15:0] hit_total
`endif
);

    localparam logic [LINE_BITS-1:0] KEY_LINE_L = LINE_BITS'(KEY_LINE);
    localparam logic [3:0]           CONFIRM_L  = 4'(CONFIRM_COUNT);
    localparam logic [7:0]           TIMEOUT_L  = 8'(TIMEOUT_FIELDS);

    typedef enum logic [2:0] {IDLE, COUNT_LINES, ARM, CAPTURE, EVALUATE} state_t;

    state_t               state, state_next;
    logic [LINE_BITS-1:0] line_cnt, line_cnt_next, line_inc;
    logic                 av_q, ready_q;
    logic                 av_rise, av_fall, ready_rise;
    logic [31:0]          cap_word, cap_word_next;
    logic                 cap_hit, cap_hit_next;
    logic [31:0]          candidate, candidate_next;
    logic [3:0]           match_cnt, match_cnt_next, match_new;
    logic [7:0]           miss_cnt, miss_cnt_next;
    logic [31:0]          key_next;
    logic                 key_valid_next, key_update_next;
    logic                 miss, hit_eval;

    assign av_rise    = active_video & ~av_q;
    assign av_fall    = ~active_video & av_q;
    assign ready_rise = det_ready & ~ready_q;
    assign line_inc   = (line_cnt == '1) ? line_cnt : line_cnt + 1'b1;

    always_comb begin
        state_next      = state;
        line_cnt_next   = line_cnt;
        cap_word_next   = cap_word;
        cap_hit_next    = cap_hit;
        candidate_next  = candidate;
        match_cnt_next  = match_cnt;
        miss_cnt_next   = miss_cnt;
        key_next        = key;
        key_valid_next  = key_valid;
        key_update_next = 1'b0;
        match_new       = '0;
        miss            = 1'b0;
        hit_eval        = 1'b0;

        case (state)
            IDLE: begin
                if (vsync) begin
                    state_next    = COUNT_LINES;
                    line_cnt_next = '0;
                end
            end
            COUNT_LINES: begin
                if (vsync) begin
                    line_cnt_next = '0;
                end else if (hsync) begin
                    line_cnt_next = line_inc;
                    if (line_inc == KEY_LINE_L) state_next = ARM;
                end
            end
            ARM: begin
                if (vsync) begin
                    miss          = 1'b1;
                    state_next    = COUNT_LINES;
                    line_cnt_next = '0;
                end else if (av_rise) begin
                    state_next   = CAPTURE;
                    cap_hit_next = 1'b0;
                end else if (hsync) begin
                    miss       = 1'b1;
                    state_next = IDLE;
                end
            end
            CAPTURE: begin
                if (vsync) begin
                    miss          = 1'b1;
                    state_next    = COUNT_LINES;
                    line_cnt_next = '0;
                end else begin
                    // ready_q tracks det_ready in every state, so a level held from
                    // before the window never looks like a fresh edge here
                    if (ready_rise && !cap_hit) begin
                        cap_word_next = det_sequence;
                        cap_hit_next  = 1'b1;
                    end
                    if (av_fall) state_next = EVALUATE;
                end
            end
            EVALUATE: begin
                state_next = IDLE;
                if (cap_hit) hit_eval = 1'b1;
                else         miss     = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (hit_eval) begin
            if (cap_word == candidate && match_cnt != '0) begin
                match_new = (match_cnt >= CONFIRM_L) ? CONFIRM_L : match_cnt + 4'd1;
            end else begin
                candidate_next = cap_word;
                match_new      = 4'd1;
            end
            match_cnt_next = match_new;
            miss_cnt_next  = '0;
            if (match_new == CONFIRM_L && (!key_valid || candidate_next != key)) begin
                key_next        = candidate_next;
                key_valid_next  = 1'b1;
                key_update_next = 1'b1;
            end
        end

        if (miss) begin
            match_cnt_next = '0;
            if (miss_cnt != '1) begin
                miss_cnt_next = miss_cnt + 8'd1;
                if (miss_cnt_next == TIMEOUT_L) begin
                    key_valid_next  = 1'b0;
                    key_update_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            line_cnt     <= '0;
            av_q         <= 1'b0;
            ready_q      <= 1'b0;
            cap_word     <= '0;
            cap_hit      <= 1'b0;
            candidate    <= '0;
            match_cnt    <= '0;
            miss_cnt     <= '0;
            key          <= '0;
            key_valid    <= 1'b0;
            key_update   <= 1'b0;
            capture_miss <= 1'b0;
            det_reset_n  <= 1'b0;
        end else begin
            state        <= state_next;
            line_cnt     <= line_cnt_next;
            av_q         <= active_video;
            ready_q      <= det_ready;
            cap_word     <= cap_word_next;
            cap_hit      <= cap_hit_next;
            candidate    <= candidate_next;
            match_cnt    <= match_cnt_next;
            miss_cnt     <= miss_cnt_next;
            key          <= key_next;
            key_valid    <= key_valid_next;
            key_update   <= key_update_next;
            capture_miss <= miss;
            det_reset_n  <= (state_next == CAPTURE);
        end
    end

`ifdef SEQ_CAPTURE_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            miss_total <= '0;
            hit_total  <= '0;
        end else begin
            if (miss && miss_total != '1)    miss_total <= miss_total + 16'd1;
            if (hit_eval && hit_total != '1) hit_total  <= hit_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sequence_capture_controller.sv
// Self-checking bench for sequence_capture_controller: directed table, hand-written
// corner cases, then randomized fields checked against a field-level reference model.
module tb_sequence_capture_controller;

    localparam int KEY_LINE = 22;
    localparam int CONFIRM  = 2;
    localparam int TIMEOUT  = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        vsync = 1'b0, hsync = 1'b0, active_video = 1'b0, det_ready = 1'b0;
    logic [31:0] det_sequence = '0;
    logic        det_reset_n;
    logic [31:0] key;
    logic        key_valid, key_update, capture_miss;
`ifdef SEQ_CAPTURE_STATS_EN
    logic [15:0] miss_total, hit_total;
`endif

    int errors = 0;
    int checks = 0;
    int upd_total = 0, miss_pulses = 0, drst_total = 0;

    always #5 clock = ~clock;

    sequence_capture_controller #(
        .KEY_LINE(KEY_LINE), .CONFIRM_COUNT(CONFIRM), .TIMEOUT_FIELDS(TIMEOUT), .LINE_BITS(10)
    ) dut (
        .clock(clock), .reset_n(reset_n), .vsync(vsync), .hsync(hsync),
        .active_video(active_video), .det_ready(det_ready), .det_sequence(det_sequence),
        .det_reset_n(det_reset_n), .key(key), .key_valid(key_valid),
        .key_update(key_update), .capture_miss(capture_miss)
`ifdef SEQ_CAPTURE_STATS_EN
        , .miss_total(miss_total), .hit_total(hit_total)
`endif
    );

    always @(negedge clock) begin
        if (key_update)   upd_total   <= upd_total + 1;
        if (capture_miss) miss_pulses <= miss_pulses + 1;
        if (det_reset_n)  drst_total  <= drst_total + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Field-level reference: one call per field, hit or miss.
    logic [31:0] m_cand, m_key;
    int          m_match, m_miss, m_hits, m_misses;
    bit          m_valid;

    task automatic model_reset();
        m_cand = '0; m_key = '0; m_match = 0; m_miss = 0; m_valid = 0;
        m_hits = 0; m_misses = 0;
    endtask

    task automatic model_field(input bit hit, input logic [31:0] w, output int upd);
        upd = 0;
        if (hit) begin
            m_hits++;
            if (m_match > 0 && w == m_cand) m_match = (m_match + 1 > CONFIRM) ? CONFIRM : m_match + 1;
            else begin m_cand = w; m_match = 1; end
            m_miss = 0;
            if (m_match == CONFIRM && (!m_valid || m_cand != m_key)) begin
                m_key = m_cand; m_valid = 1; upd = 1;
            end
        end else begin
            m_misses++;
            m_match = 0;
            if (m_miss < 255) begin
                m_miss++;
                if (m_miss == TIMEOUT) begin m_valid = 0; upd = 1; end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // scen: 0 normal capture, 1 no ready edge, 2 ready held high beforehand,
    //       3 extra hsync while armed, 4 vsync interrupts capture
    task automatic run_field(input int scen, input logic [31:0] word, input bit simul,
                             input int len, output int edrst);
        edrst = (scen == 3) ? 0 : ((scen == 4) ? 3 : len);
        det_ready = (scen == 2);
        vsync = 1'b1; hsync = simul; tick(); vsync = 1'b0; hsync = 1'b0; tick();
        for (int i = 0; i < KEY_LINE; i++) begin
            hsync = 1'b1; tick(); hsync = 1'b0; tick(); tick();
        end
        if (scen == 3) begin hsync = 1'b1; tick(); hsync = 1'b0; tick(); end
        det_sequence = word;
        active_video = 1'b1; tick();
        for (int c = 1; c < len; c++) begin
            if (c == 2 && (scen == 0 || scen == 4)) det_ready = 1'b1;
            if (scen == 4 && c == 3) begin
                check("irq_drst_before", 32'(det_reset_n), 32'd1);
                vsync = 1'b1; tick(); vsync = 1'b0;
                check("irq_drst_after", 32'(det_reset_n), 32'd0);
                check("irq_miss_pulse", 32'(capture_miss), 32'd1);
                break;
            end
            tick();
        end
        active_video = 1'b0;
        repeat (5) tick();
        det_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_field(input string tag, input int scen, input logic [31:0] w,
                            input bit simul, input int len, input logic [31:0] ekey,
                            input bit evalid, input int eupd, input int emiss);
        int u0, m0, d0, edrst, dummy;
        u0 = upd_total; m0 = miss_pulses; d0 = drst_total;
        run_field(scen, w, simul, len, edrst);
        model_field(scen == 0, w, dummy);
        check({tag, "_key"},   key, ekey);
        check({tag, "_valid"}, 32'(key_valid), 32'(evalid));
        check({tag, "_upd"},   32'(upd_total - u0), 32'(eupd));
        check({tag, "_miss"},  32'(miss_pulses - m0), 32'(emiss));
        check({tag, "_drst"},  32'(drst_total - d0), 32'(edrst));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_drst"},  32'(det_reset_n), 32'd0);
        check({tag, "_key"},   key, 32'd0);
        check({tag, "_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_upd"},   32'(key_update), 32'd0);
        check({tag, "_miss"},  32'(capture_miss), 32'd0);
`ifdef SEQ_CAPTURE_STATS_EN
        check({tag, "_mtot"},  32'(miss_total), 32'd0);
        check({tag, "_htot"},  32'(hit_total), 32'd0);
`endif
    endtask

    typedef struct {
        int          scen;
        logic [31:0] word;
        bit          simul;
        logic [31:0] ekey;
        bit          evalid;
        int          eupd;
        int          emiss;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int eupd, r, scen, len;
        bit simul;
        logic [31:0] w;

        tbl[0]  = '{0, 32'hA5C3_0F12, 0, 32'h0000_0000, 0, 0, 0};
        tbl[1]  = '{0, 32'hA5C3_0F12, 0, 32'hA5C3_0F12, 1, 1, 0};
        tbl[2]  = '{0, 32'h1111_1111, 0, 32'hA5C3_0F12, 1, 0, 0};
        tbl[3]  = '{0, 32'h2222_2222, 0, 32'hA5C3_0F12, 1, 0, 0};
        tbl[4]  = '{0, 32'h2222_2222, 0, 32'h2222_2222, 1, 1, 0};
        tbl[5]  = '{0, 32'h2222_2222, 0, 32'h2222_2222, 1, 0, 0};
        tbl[6]  = '{2, 32'hDEAD_BEEF, 0, 32'h2222_2222, 1, 0, 1};
        for (int i = 7; i < 13; i++) tbl[i] = '{1, 32'hDEAD_BEEF, 0, 32'h2222_2222, 1, 0, 1};
        tbl[13] = '{1, 32'hDEAD_BEEF, 0, 32'h2222_2222, 0, 1, 1};
        tbl[14] = '{0, 32'h3333_3333, 0, 32'h2222_2222, 0, 0, 0};
        tbl[15] = '{0, 32'h3333_3333, 1, 32'h3333_3333, 1, 1, 0};
        tbl[16] = '{3, 32'h3333_3333, 0, 32'h3333_3333, 1, 0, 1};

        #3 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_idle_outputs("reset");
        reset_n = 1'b1;
        tick(); tick();
        check_idle_outputs("post_reset");
        model_reset();

        for (int i = 0; i < 17; i++)
            do_field($sformatf("tbl%0d", i), tbl[i].scen, tbl[i].word, tbl[i].simul, 8,
                     tbl[i].ekey, tbl[i].evalid, tbl[i].eupd, tbl[i].emiss);

        do_field("irq",   4, 32'h5555_5555, 0, 8, 32'h3333_3333, 1, 0, 1);
        do_field("after1", 0, 32'h4444_4444, 0, 8, 32'h3333_3333, 1, 0, 0);
        do_field("after2", 0, 32'h4444_4444, 0, 8, 32'h4444_4444, 1, 1, 0);
`ifdef SEQ_CAPTURE_STATS_EN
        check("stats_miss", 32'(miss_total), 32'd10);
        check("stats_hit",  32'(hit_total), 32'd10);
`endif

        // Asynchronous reset in the middle of a capture window.
        vsync = 1'b1; tick(); vsync = 1'b0; tick();
        for (int i = 0; i < KEY_LINE; i++) begin
            hsync = 1'b1; tick(); hsync = 1'b0; tick();
        end
        active_video = 1'b1; tick(); tick();
        det_ready = 1'b1; tick(); tick();
        check("midcap_drst_high", 32'(det_reset_n), 32'd1);
        check("midcap_valid_high", 32'(key_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("midcap_reset");
        active_video = 1'b0; det_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick();
        model_reset();

        for (int f = 0; f < 45; f++) begin
            r = $urandom_range(0, 9);
            if (f < 30) scen = (r < 6) ? 0 : r - 5;
            else        scen = (r < 1) ? 0 : $urandom_range(1, 4);
            if ($urandom_range(0, 4) == 0)      w = $urandom;
            else if ($urandom_range(0, 1) == 0) w = 32'h0BAD_F00D;
            else                                w = 32'hC0DE_1234;
            simul = ($urandom_range(0, 3) == 0);
            len = $urandom_range(5, 10);
            begin
                int u0, m0, d0, edrst;
                u0 = upd_total; m0 = miss_pulses; d0 = drst_total;
                run_field(scen, w, simul, len, edrst);
                model_field(scen == 0, w, eupd);
                check($sformatf("rnd%0d_key", f),   key, m_key);
                check($sformatf("rnd%0d_valid", f), 32'(key_valid), 32'(m_valid));
                check($sformatf("rnd%0d_upd", f),   32'(upd_total - u0), 32'(eupd));
                check($sformatf("rnd%0d_miss", f),  32'(miss_pulses - m0), (scen == 0) ? 32'd0 : 32'd1);
                check($sformatf("rnd%0d_drst", f),  32'(drst_total - d0), 32'(edrst));
            end
        end
`ifdef SEQ_CAPTURE_STATS_EN
        check("rnd_stats_miss", 32'(miss_total), 32'(m_misses));
        check("rnd_stats_hit",  32'(hit_total), 32'(m_hits));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
